// File: rtl/program_loader_if.sv
// Host word channel into the program loader: 16-bit instruction words over valid/ready.
interface program_loader_if;
  logic        word_valid;
  logic [15:0] word_data;
  logic        word_ready;

  modport master (output word_valid, output word_data, input word_ready);
  modport slave  (input word_valid, input word_data, output word_ready);
endinterface

// File: rtl/program_loader.sv
// Serialises 16-bit instruction words into two strobed bytes for the instruction-load port,
// holding the processor halted while loading. LOADER_CHECKSUM_EN adds a running word checksum.
module program_loader #(
  parameter int WORD_COUNT    = 64,
  parameter int STROBE_CYCLES = 2,
  parameter int GAP_CYCLES    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_start,
  input  logic                   load_end,
  program_loader_if.slave        host,
  output logic [7:0]             input_instruction,
  output logic                   button,
  output logic                   clk_enable,
  output logic                   busy,
  output logic [6:0]             words_loaded,
  output logic [15:0]            checksum
);

  localparam int MAX_CYC = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [6:0] WORD_COUNT_W = 7'(WORD_COUNT);

  typedef enum logic [2:0] {IDLE, WAIT_WORD, SETUP, STROBE, GAP, RUN} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               byte_sel_reg, byte_sel_next;
  logic [15:0]        word_reg, word_next;
  logic [6:0]         words_loaded_reg, words_loaded_next;
  logic [7:0]         instr_reg, instr_next;
  logic               button_reg, button_next;
  logic               clk_enable_reg, clk_enable_next;
  logic               busy_reg, busy_next;
  logic               word_ready_reg, word_ready_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      byte_sel_reg     <= 1'b0;
      word_reg         <= '0;
      words_loaded_reg <= '0;
      instr_reg        <= '0;
      button_reg       <= 1'b0;
      clk_enable_reg   <= 1'b0;
      busy_reg         <= 1'b0;
      word_ready_reg   <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      byte_sel_reg     <= byte_sel_next;
      word_reg         <= word_next;
      words_loaded_reg <= words_loaded_next;
      instr_reg        <= instr_next;
      button_reg       <= button_next;
      clk_enable_reg   <= clk_enable_next;
      busy_reg         <= busy_next;
      word_ready_reg   <= word_ready_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    byte_sel_next     = byte_sel_reg;
    word_next         = word_reg;
    words_loaded_next = words_loaded_reg;

    case (state_reg)
      IDLE, RUN: begin
        if (load_start) begin
          state_next        = WAIT_WORD;
          words_loaded_next = '0;
        end
      end
      WAIT_WORD: begin
        // A handshake takes priority over an early end request in the same cycle.
        if (host.word_valid && word_ready_reg) begin
          word_next     = host.word_data;
          byte_sel_next = 1'b0;
          state_next    = SETUP;
        end else if (load_end) begin
          state_next = RUN;
        end
      end
      SETUP: begin
        state_next = STROBE;
        cnt_next   = CNT_W'(STROBE_CYCLES - 1);
      end
      STROBE: begin
        if (cnt_reg == '0) begin
          state_next = GAP;
          cnt_next   = CNT_W'(GAP_CYCLES - 1);
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end else if (!byte_sel_reg) begin
          byte_sel_next = 1'b1;
          state_next    = SETUP;
        end else begin
          if (words_loaded_reg < WORD_COUNT_W)
            words_loaded_next = words_loaded_reg + 7'd1;
          if (words_loaded_next == WORD_COUNT_W || load_end)
            state_next = RUN;
          else
            state_next = WAIT_WORD;
        end
      end
      default: state_next = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    button_next     = (state_next == STROBE);
    clk_enable_next = (state_next == RUN);
    word_ready_next = (state_next == WAIT_WORD);
    busy_next       = (state_next == WAIT_WORD) || (state_next == SETUP) ||
                      (state_next == STROBE)    || (state_next == GAP);
    if ((state_next == SETUP) || (state_next == STROBE) || (state_next == GAP))
      instr_next = byte_sel_next ? word_next[7:0] : word_next[15:8];
    else
      instr_next = 8'h00;
  end

  assign input_instruction = instr_reg;
  assign button            = button_reg;
  assign clk_enable        = clk_enable_reg;
  assign busy              = busy_reg;
  assign words_loaded      = words_loaded_reg;
  assign host.word_ready   = word_ready_reg;

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] checksum_reg;
  logic        word_done;
  logic        load_clear;

  // Same cycle as the words_loaded increment: end of the second byte's gap.
  assign word_done  = (state_reg == GAP) && (cnt_reg == '0) && byte_sel_reg;
  assign load_clear = ((state_reg == IDLE) || (state_reg == RUN)) && load_start;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      checksum_reg <= '0;
    else if (load_clear)
      checksum_reg <= '0;
    else if (word_done)
      checksum_reg <= checksum_reg + word_reg;
  end

  assign checksum = checksum_reg;
`else
  assign checksum = 16'h0000;
`endif

endmodule
